// File: rtl/track_ctrl.sv
// Frame-level box tracker: search/acquire/lock/coast FSM that drives the detector ROI and a
// validated tracked box with centroid. Optional macro TRACK_SMOOTH_EN smooths trk_* while locked.
module track_ctrl #(
  parameter int H_LO        = 169,
  parameter int H_HI        = 799,
  parameter int V_LO        = 51,
  parameter int V_HI        = 499,
  parameter int MIN_W       = 8,
  parameter int MIN_H       = 8,
  parameter int ACQ_HITS    = 3,
  parameter int LOST_MISSES = 4,
  parameter int MARGIN      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_vld,
  input  logic [10:0] box_x_min,
  input  logic [10:0] box_x_max,
  input  logic [9:0]  box_y_min,
  input  logic [9:0]  box_y_max,
  output logic [10:0] roi_x_lo,
  output logic [10:0] roi_x_hi,
  output logic [9:0]  roi_y_lo,
  output logic [9:0]  roi_y_hi,
  output logic [10:0] trk_x_min,
  output logic [10:0] trk_x_max,
  output logic [9:0]  trk_y_min,
  output logic [9:0]  trk_y_max,
  output logic [10:0] cx,
  output logic [9:0]  cy,
  output logic        locked,
  output logic        upd,
  output logic        lost
);

  localparam int HCW = $clog2(ACQ_HITS + 1);
  localparam int MCW = $clog2(LOST_MISSES + 1);

  localparam logic [HCW-1:0]    ACQ_LAST  = HCW'(ACQ_HITS - 1);
  localparam logic [MCW-1:0]    MISS_LAST = MCW'(LOST_MISSES - 1);
  localparam logic [10:0]       MIN_W_C   = 11'(MIN_W);
  localparam logic [9:0]        MIN_H_C   = 10'(MIN_H);
  localparam logic [10:0]       FULL_X_LO = 11'(H_LO);
  localparam logic [10:0]       FULL_X_HI = 11'(H_HI);
  localparam logic [9:0]        FULL_Y_LO = 10'(V_LO);
  localparam logic [9:0]        FULL_Y_HI = 10'(V_HI);
  localparam logic signed [12:0] MARGIN_X = 13'(MARGIN);
  localparam logic signed [12:0] H_LO_S   = 13'(H_LO);
  localparam logic signed [12:0] H_HI_S   = 13'(H_HI);
  localparam logic signed [11:0] MARGIN_Y = 12'(MARGIN);
  localparam logic signed [11:0] V_LO_S   = 12'(V_LO);
  localparam logic signed [11:0] V_HI_S   = 12'(V_HI);

  typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED, S_COAST} state_e;

  state_e         state_q;
  logic [HCW-1:0] hit_cnt_q;
  logic [MCW-1:0] miss_cnt_q;

  logic        s1_vld_q, hit_q;
  logic [10:0] b_x_min_q, b_x_max_q;
  logic [9:0]  b_y_min_q, b_y_max_q;

  logic [10:0] roi_x_lo_q, roi_x_hi_q, trk_x_min_q, trk_x_max_q, cx_q;
  logic [9:0]  roi_y_lo_q, roi_y_hi_q, trk_y_min_q, trk_y_max_q, cy_q;
  logic        locked_q, upd_q, lost_q;

  // Stage 1: qualify and capture the box; results arriving while the pipe is busy are dropped.
  logic        accept, hit_in;
  logic [10:0] box_w;
  logic [9:0]  box_h;

  assign accept = res_vld && !s1_vld_q && !upd_q;
  assign box_w  = box_x_max - box_x_min;
  assign box_h  = box_y_max - box_y_min;
  assign hit_in = (box_x_min <= box_x_max) && (box_y_min <= box_y_max) &&
                  (box_w >= MIN_W_C) && (box_h >= MIN_H_C);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      hit_q     <= 1'b0;
      b_x_min_q <= '0;
      b_x_max_q <= '0;
      b_y_min_q <= '0;
      b_y_max_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        hit_q     <= hit_in;
        b_x_min_q <= box_x_min;
        b_x_max_q <= box_x_max;
        b_y_min_q <= box_y_min;
        b_y_max_q <= box_y_max;
      end
    end
  end

`ifdef TRACK_SMOOTH_EN
  function automatic logic [10:0] avg_x(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b} + 12'd1;
    return 11'(s >> 1);
  endfunction

  function automatic logic [9:0] avg_y(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b} + 11'd1;
    return 10'(s >> 1);
  endfunction
`endif

  // Next tracked box, its centroid, and the clamped locked ROI around it.
  logic        upd_trk;
  logic [10:0] trk_x_min_d, trk_x_max_d, cx_d, roi_x_lo_lk, roi_x_hi_lk;
  logic [9:0]  trk_y_min_d, trk_y_max_d, cy_d, roi_y_lo_lk, roi_y_hi_lk;
  logic [11:0] sum_x;
  logic [10:0] sum_y;
  logic signed [12:0] x_lo_s, x_hi_s;
  logic signed [11:0] y_lo_s, y_hi_s;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    upd_trk     = s1_vld_q && hit_q && ((state_q != S_SEARCH) || (ACQ_HITS <= 1));
    trk_x_min_d = trk_x_min_q;
    trk_x_max_d = trk_x_max_q;
    trk_y_min_d = trk_y_min_q;
    trk_y_max_d = trk_y_max_q;
    if (upd_trk) begin
      trk_x_min_d = b_x_min_q;
      trk_x_max_d = b_x_max_q;
      trk_y_min_d = b_y_min_q;
      trk_y_max_d = b_y_max_q;
`ifdef TRACK_SMOOTH_EN
      if (state_q == S_LOCKED || state_q == S_COAST) begin
        trk_x_min_d = avg_x(trk_x_min_q, b_x_min_q);
        trk_x_max_d = avg_x(trk_x_max_q, b_x_max_q);
        trk_y_min_d = avg_y(trk_y_min_q, b_y_min_q);
        trk_y_max_d = avg_y(trk_y_max_q, b_y_max_q);
      end
`endif
    end

    sum_x = {1'b0, trk_x_min_d} + {1'b0, trk_x_max_d};
    sum_y = {1'b0, trk_y_min_d} + {1'b0, trk_y_max_d};
    cx_d  = 11'(sum_x >> 1);
    cy_d  = 10'(sum_y >> 1);

    // Widened signed math: low edge may go negative, high edge may exceed the coordinate range.
    x_lo_s = $signed({2'b00, trk_x_min_d}) - MARGIN_X;
    x_hi_s = $signed({2'b00, trk_x_max_d}) + MARGIN_X;
    y_lo_s = $signed({2'b00, trk_y_min_d}) - MARGIN_Y;
    y_hi_s = $signed({2'b00, trk_y_max_d}) + MARGIN_Y;
    roi_x_lo_lk = (x_lo_s < H_LO_S) ? FULL_X_LO : 11'(x_lo_s);
    roi_x_hi_lk = (x_hi_s > H_HI_S) ? FULL_X_HI : 11'(x_hi_s);
    roi_y_lo_lk = (y_lo_s < V_LO_S) ? FULL_Y_LO : 10'(y_lo_s);
    roi_y_hi_lk = (y_hi_s > V_HI_S) ? FULL_Y_HI : 10'(y_hi_s);
  end

  // Stage 2: FSM and registered outputs, updated once per accepted result.
  // NOTE: all state, datapath included, is reset so a mid-frame rst_n restores defaults at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SEARCH;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      roi_x_lo_q  <= FULL_X_LO;
      roi_x_hi_q  <= FULL_X_HI;
      roi_y_lo_q  <= FULL_Y_LO;
      roi_y_hi_q  <= FULL_Y_HI;
      trk_x_min_q <= '0;
      trk_x_max_q <= '0;
      trk_y_min_q <= '0;
      trk_y_max_q <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      locked_q    <= 1'b0;
      upd_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      upd_q  <= 1'b0;
      lost_q <= 1'b0;
      if (s1_vld_q) begin
        upd_q       <= 1'b1;
        trk_x_min_q <= trk_x_min_d;
        trk_x_max_q <= trk_x_max_d;
        trk_y_min_q <= trk_y_min_d;
        trk_y_max_q <= trk_y_max_d;
        cx_q        <= cx_d;
        cy_q        <= cy_d;
        roi_x_lo_q  <= FULL_X_LO;
        roi_x_hi_q  <= FULL_X_HI;
        roi_y_lo_q  <= FULL_Y_LO;
        roi_y_hi_q  <= FULL_Y_HI;
        locked_q    <= 1'b0;
        if (((state_q == S_SEARCH || state_q == S_ACQUIRE) && hit_q &&
             (ACQ_HITS <= 1 || (state_q == S_ACQUIRE && hit_cnt_q == ACQ_LAST))) ||
            ((state_q == S_LOCKED || state_q == S_COAST) &&
             (hit_q || (LOST_MISSES > 1 && (state_q == S_LOCKED || miss_cnt_q != MISS_LAST))))) begin
          roi_x_lo_q <= roi_x_lo_lk;
          roi_x_hi_q <= roi_x_hi_lk;
          roi_y_lo_q <= roi_y_lo_lk;
          roi_y_hi_q <= roi_y_hi_lk;
          locked_q   <= 1'b1;
        end
        case (state_q)
          S_SEARCH: begin
            if (hit_q && ACQ_HITS <= 1) begin
              state_q <= S_LOCKED;
            end else if (hit_q) begin
              state_q   <= S_ACQUIRE;
              hit_cnt_q <= HCW'(1);
            end
          end
          S_ACQUIRE: begin
            if (!hit_q) begin
              state_q   <= S_SEARCH;
              hit_cnt_q <= '0;
            end else if (hit_cnt_q == ACQ_LAST) begin
              state_q    <= S_LOCKED;
              hit_cnt_q  <= '0;
              miss_cnt_q <= '0;
            end else begin
              hit_cnt_q <= hit_cnt_q + 1'b1;
            end
          end
          S_LOCKED: begin
            if (!hit_q && LOST_MISSES <= 1) begin
              state_q <= S_SEARCH;
              lost_q  <= 1'b1;
            end else if (!hit_q) begin
              state_q    <= S_COAST;
              miss_cnt_q <= MCW'(1);
            end
          end
          S_COAST: begin
            if (hit_q) begin
              state_q    <= S_LOCKED;
              miss_cnt_q <= '0;
            end else if (miss_cnt_q == MISS_LAST) begin
              state_q    <= S_SEARCH;
              miss_cnt_q <= '0;
              lost_q     <= 1'b1;
            end else begin
              miss_cnt_q <= miss_cnt_q + 1'b1;
            end
          end
          default: state_q <= S_SEARCH;
        endcase
      end
    end
  end

  assign roi_x_lo  = roi_x_lo_q;
  assign roi_x_hi  = roi_x_hi_q;
  assign roi_y_lo  = roi_y_lo_q;
  assign roi_y_hi  = roi_y_hi_q;
  assign trk_x_min = trk_x_min_q;
  assign trk_x_max = trk_x_max_q;
  assign trk_y_min = trk_y_min_q;
  assign trk_y_max = trk_y_max_q;
  assign cx        = cx_q;
  assign cy        = cy_q;
  assign locked    = locked_q;
  assign upd       = upd_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_track_ctrl.sv
// Scoreboard bench for track_ctrl: directed plan frames plus random frames checked
// against a frame-level reference model; a monitor compares every upd pulse.
module tb_track_ctrl;

  localparam int H_LO = 169, H_HI = 799, V_LO = 51, V_HI = 499;
  localparam int MIN_W = 8, MIN_H = 8, ACQ_HITS = 3, LOST_MISSES = 4, MARGIN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_vld = 1'b0;
  logic [10:0] box_x_min = '0, box_x_max = '0;
  logic [9:0]  box_y_min = '0, box_y_max = '0;
  logic [10:0] roi_x_lo, roi_x_hi, trk_x_min, trk_x_max, cx;
  logic [9:0]  roi_y_lo, roi_y_hi, trk_y_min, trk_y_max, cy;
  logic        locked, upd, lost;

  track_ctrl dut (
    .clk(clk), .rst_n(rst_n), .res_vld(res_vld),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max),
    .roi_x_lo(roi_x_lo), .roi_x_hi(roi_x_hi), .roi_y_lo(roi_y_lo), .roi_y_hi(roi_y_hi),
    .trk_x_min(trk_x_min), .trk_x_max(trk_x_max),
    .trk_y_min(trk_y_min), .trk_y_max(trk_y_max),
    .cx(cx), .cy(cy), .locked(locked), .upd(upd), .lost(lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rxl, rxh, ryl, ryh;
    int txl, txh, tyl, tyh;
    int ecx, ecy;
    int elocked, elost;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: one call per accepted frame, expressed as streak/miss counting.
  bit m_locked;
  int m_streak, m_misses;
  int m_txl, m_txh, m_tyl, m_tyh;

  function automatic void model_reset();
    m_locked = 0; m_streak = 0; m_misses = 0;
    m_txl = 0; m_txh = 0; m_tyl = 0; m_tyh = 0;
  endfunction

  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction

  function automatic exp_t model_frame(int x0, int x1, int y0, int y1);
    exp_t e;
    bit hit;
    hit = (x0 <= x1) && (y0 <= y1) && (x1 - x0 >= MIN_W) && (y1 - y0 >= MIN_H);
    e.elost = 0;
    if (!m_locked) begin
      if (hit) begin
        if (m_streak > 0 || ACQ_HITS == 1) begin
          m_txl = x0; m_txh = x1; m_tyl = y0; m_tyh = y1;
        end
        m_streak++;
        if (m_streak >= ACQ_HITS) begin
          m_locked = 1; m_streak = 0; m_misses = 0;
        end
      end else begin
        m_streak = 0;
      end
    end else if (hit) begin
`ifdef TRACK_SMOOTH_EN
      m_txl = (m_txl + x0 + 1) / 2; m_txh = (m_txh + x1 + 1) / 2;
      m_tyl = (m_tyl + y0 + 1) / 2; m_tyh = (m_tyh + y1 + 1) / 2;
`else
      m_txl = x0; m_txh = x1; m_tyl = y0; m_tyh = y1;
`endif
      m_misses = 0;
    end else begin
      m_misses++;
      if (m_misses >= LOST_MISSES) begin
        m_locked = 0; m_misses = 0; e.elost = 1;
      end
    end
    e.txl = m_txl; e.txh = m_txh; e.tyl = m_tyl; e.tyh = m_tyh;
    e.ecx = (m_txl + m_txh) / 2;
    e.ecy = (m_tyl + m_tyh) / 2;
    e.elocked = m_locked;
    if (m_locked) begin
      e.rxl = imax(m_txl - MARGIN, H_LO); e.rxh = imin(m_txh + MARGIN, H_HI);
      e.ryl = imax(m_tyl - MARGIN, V_LO); e.ryh = imin(m_tyh + MARGIN, V_HI);
    end else begin
      e.rxl = H_LO; e.rxh = H_HI; e.ryl = V_LO; e.ryh = V_HI;
    end
    e.due = 0;
    return e;
  endfunction

  // Monitor: every upd pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && upd) begin
      if (sb.size() == 0) begin
        check("upd_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("upd_latency", cyc, mon_e.due);
        check("roi_x_lo", roi_x_lo, mon_e.rxl);
        check("roi_x_hi", roi_x_hi, mon_e.rxh);
        check("roi_y_lo", roi_y_lo, mon_e.ryl);
        check("roi_y_hi", roi_y_hi, mon_e.ryh);
        check("trk_x_min", trk_x_min, mon_e.txl);
        check("trk_x_max", trk_x_max, mon_e.txh);
        check("trk_y_min", trk_y_min, mon_e.tyl);
        check("trk_y_max", trk_y_max, mon_e.tyh);
        check("cx", cx, mon_e.ecx);
        check("cy", cy, mon_e.ecy);
        check("locked", locked, mon_e.elocked);
        check("lost", lost, mon_e.elost);
      end
    end else if (rst_n && lost) begin
      check("lost_without_upd", 32'd1, 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One accepted frame; junk_hold keeps res_vld high 1-2 extra cycles with a
  // different box, which the DUT must drop.
  task automatic send(input int x0, input int x1, input int y0, input int y1, input int junk_hold);
    exp_t e;
    @(posedge clk); #1;
    box_x_min = 11'(x0); box_x_max = 11'(x1);
    box_y_min = 10'(y0); box_y_max = 10'(y1);
    res_vld = 1'b1;
    e = model_frame(x0, x1, y0, y1);
    e.due = cyc + 2;
    sb.push_back(e);
    for (int j = 0; j < junk_hold; j++) begin
      @(posedge clk); #1;
      box_x_min = 11'(x0 ^ 11'h155); box_x_max = 11'd0;
      box_y_min = 10'd600;          box_y_max = 10'(y1 ^ 10'h0aa);
    end
    @(posedge clk); #1;
    res_vld = 1'b0;
    idle(1 + (junk_hold > 1 ? 0 : 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_roi_x_lo"}, roi_x_lo, H_LO);
    check({tag, "_roi_x_hi"}, roi_x_hi, H_HI);
    check({tag, "_roi_y_lo"}, roi_y_lo, V_LO);
    check({tag, "_roi_y_hi"}, roi_y_hi, V_HI);
    check({tag, "_trk"}, {trk_x_min, trk_x_max, trk_y_min[9:0]}, 32'd0);
    check({tag, "_cxcy"}, {cx, cy}, 32'd0);
    check({tag, "_flags"}, {locked, upd, lost}, 32'd0);
  endtask

  task automatic rand_box(output int x0, output int x1, output int y0, output int y1);
    case ($urandom_range(0, 7))
      0: begin x0 = 800; x1 = 0; y0 = 600; y1 = 0; end
      1: begin
        x0 = $urandom_range(170, 700); x1 = x0 + $urandom_range(5, 10);
        y0 = $urandom_range(52, 400);  y1 = y0 + $urandom_range(5, 10);
      end
      2: begin
        x0 = $urandom_range(0, 2047); x1 = $urandom_range(0, 2047);
        y0 = $urandom_range(0, 1023); y1 = $urandom_range(0, 1023);
      end
      3: begin
        x0 = $urandom_range(1900, 2047); x1 = 2047;
        y0 = $urandom_range(0, 20);      y1 = 1023;
      end
      default: begin
        x0 = $urandom_range(170, 700); x1 = x0 + $urandom_range(8, 90);
        y0 = $urandom_range(52, 400);  y1 = y0 + $urandom_range(8, 90);
      end
    endcase
  endtask

  initial begin
    int x0, x1, y0, y1;
    model_reset();
    idle(3);
    #1 check_reset_outputs("in_reset");
    rst_n = 1'b1;
    idle(4);
    #1 check_reset_outputs("idle");

    // Acquire and lock on a stable box.
    repeat (3) send(300, 400, 100, 200, 0);
    idle(2);
    check("plan_locked", locked, 1);
    check("plan_trk", {trk_x_min, trk_x_max}, {11'd300, 11'd400});
    check("plan_cx", cx, 350);
    check("plan_cy", cy, 150);
    check("plan_roi_x", {roi_x_lo, roi_x_hi}, {11'd268, 11'd432});
    check("plan_roi_y", {roi_y_lo, roi_y_hi}, {10'd68, 10'd232});

`ifdef TRACK_SMOOTH_EN
    send(311, 400, 100, 200, 0);
    idle(2);
    check("smooth_trk_x_min", trk_x_min, 306);
`endif

    // Coast on empty boxes, then lose the target.
    repeat (3) send(800, 0, 600, 0, 0);
    idle(2);
    check("coast_locked", locked, 1);
    check("coast_trk_x_max", trk_x_max, 400);
    send(800, 0, 600, 0, 0);
    idle(2);
    check("lost_locked", locked, 0);
    check("lost_roi", {roi_x_lo, roi_x_hi, roi_y_lo[9:0]}, {11'd169, 11'd799, 10'd51});

    // ROI clamps at the full-window edges.
    repeat (3) send(180, 790, 60, 495, 0);
    idle(2);
    check("clamp_roi_x", {roi_x_lo, roi_x_hi}, {11'd169, 11'd799});
    check("clamp_roi_y", {roi_y_lo, roi_y_hi}, {10'd51, 10'd499});

    // Back to SEARCH, one hit into ACQUIRE, then a 5 px box resets the streak.
    repeat (4) send(800, 0, 600, 0, 0);
    send(300, 400, 100, 200, 0);
    send(300, 305, 100, 200, 0);
    repeat (2) send(300, 400, 100, 200, 0);
    idle(2);
    check("narrow_restarts_acq", locked, 0);
    send(300, 400, 100, 200, 0);
    idle(2);
    check("narrow_then_lock", locked, 1);

    // Closely spaced results are dropped (junk would be misses if taken).
    send(320, 420, 120, 220, 1);
    send(330, 430, 130, 230, 2);

    // Mid-frame reset discards the in-flight result.
    @(posedge clk); #1;
    box_x_min = 11'd500; box_x_max = 11'd600; box_y_min = 10'd200; box_y_max = 10'd300;
    res_vld = 1'b1;
    @(posedge clk); #1;
    res_vld = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1 check_reset_outputs("mid_reset");
    idle(2); #1;
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 400; i++) begin
      rand_box(x0, x1, y0, y1);
      send(x0, x1, y0, y1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
      idle($urandom_range(0, 2));
    end

    idle(6);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
